imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 37 +++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_csum.sv | 26 ++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction memory loader.
// State encodings, output bundle and the default word width.
package loader_pkg;

    localparam int WORD_W_DEF = 19;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic done;
        logic err;
        logic core_rst_n;
    } ctl_t;

    // Registered status outputs that hold for the whole of each state
    function automatic ctl_t ctl_of(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_LOAD:  begin c.in_ready = 1'b1; c.busy = 1'b1; end
            S_CHECK: begin c.in_ready = 1'b1; c.busy = 1'b1; end
            S_DONE:  begin c.done = 1'b1; c.core_rst_n = 1'b1; end
            S_ERROR: c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Load-stream and instruction-memory write bundle.
// master drives start/length/data; slave is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = loader_pkg::WORD_W_DEF
);
    logic              start;
    logic [ADDR_W:0]   length;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wd;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, length, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wd,
        input  core_rst_n, busy, done, err
    );

    modport slave (
        input  start, length, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wd,
        output core_rst_n, busy, done, err
    );
endinterface

// File: rtl/imem_loader_csum.sv
// Running modulo-2^WORD_W sum of loaded words.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_csum #(
    parameter int WORD_W = loader_pkg::WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] sum_o
);
    logic [WORD_W-1:0] sum_q;

    // Clear wins over add; wraps naturally at WORD_W bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_q <= '0;
        else if (clr_i)
            sum_q <= '0;
        else if (add_i)
            sum_q <= sum_q + data_i;
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/imem_loader.sv
// Streams words into instruction memory, then releases the core.
// Optional trailing checksum beat: define LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHECK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t            state_q;
    ctl_t              ctl_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wd_q;
    logic              accept;

    // start is only honoured outside LOAD/CHECK
    assign accept = bus.start &&
        (state_q inside {S_IDLE, S_DONE, S_ERROR});

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;

    loader_csum #(.WORD_W(WORD_W)) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .add_i  (state_q == S_LOAD && bus.in_valid),
        .data_i (bus.in_data),
        .sum_o  (sum)
    );
`endif

    // Loader FSM; outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctl_q   <= ctl_of(S_IDLE);
            cnt_q   <= '0;
            last_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q;
                        wd_q   <= bus.in_data;
                        cnt_q  <= cnt_q + ADDR_W'(1);
                        if (cnt_q == last_q) begin
                            state_q <= S_FIN;
                            ctl_q   <= ctl_of(S_FIN);
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.in_valid) begin
                        if (bus.in_data == sum) begin
                            state_q <= S_DONE;
                            ctl_q   <= ctl_of(S_DONE);
                        end else begin
                            state_q <= S_ERROR;
                            ctl_q   <= ctl_of(S_ERROR);
                        end
                    end
                end
`endif
                default: begin
                    if (accept) begin
                        cnt_q  <= '0;
                        last_q <= bus.length[ADDR_W-1:0] - ADDR_W'(1);
                        if (bus.length == '0) begin
                            state_q <= S_FIN;
                            ctl_q   <= ctl_of(S_FIN);
                        end else if (bus.length > DEPTH) begin
                            state_q <= S_ERROR;
                            ctl_q   <= ctl_of(S_ERROR);
                        end else begin
                            state_q <= S_LOAD;
                            ctl_q   <= ctl_of(S_LOAD);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = ctl_q.in_ready;
    assign bus.busy       = ctl_q.busy;
    assign bus.done       = ctl_q.done;
    assign bus.err        = ctl_q.err;
    assign bus.core_rst_n = ctl_q.core_rst_n;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wd    = wd_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    localparam int AW = 10;
    localparam int WW = 19;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [31:0] wa[4] = '{32'h00001, 32'h7FFFF, 32'h12345, 32'h00000};

    imem_loader_if #(.ADDR_W(AW), .WORD_W(WW)) bus();

    imem_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wq_a.push_back(32'(bus.imem_addr));
            wq_d.push_back(32'(bus.imem_wd));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        nvec++;
        assert (obs === want) else begin
            nerr++;
            $error("FAIL %s got %h want %h", tag, obs, want);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        chk({tag, ".done"}, 32'(bus.done), 0);
        chk({tag, ".err"}, 32'(bus.err), 0);
        chk({tag, ".core_rst_n"}, 32'(bus.core_rst_n), 0);
        chk({tag, ".we"}, 32'(bus.imem_we), 0);
        chk({tag, ".addr"}, 32'(bus.imem_addr), 0);
        chk({tag, ".wd"}, 32'(bus.imem_wd), 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.length   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick;
        chk_rst("rst0");
        rst = 1'b0;
        tick;

`ifndef LOADER_CHECKSUM_EN
        // Basic 4-word load, back-to-back
        bus.start  = 1'b1;
        bus.length = 11'd4;
        tick;
        bus.start = 1'b0;
        wq_a.delete();
        wq_d.delete();
        chk("A.ready", 32'(bus.in_ready), 1);
        chk("A.busy", 32'(bus.busy), 1);
        chk("A.crst0", 32'(bus.core_rst_n), 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = WW'(wa[i]);
            tick;
            chk("A.we", 32'(bus.imem_we), 1);
            chk("A.addr", 32'(bus.imem_addr), 32'(i));
            chk("A.wd", 32'(bus.imem_wd), wa[i]);
            chk("A.crst", 32'(bus.core_rst_n), 32'(i == 3));
            chk("A.rdy", 32'(bus.in_ready), 32'(i != 3));
        end
        bus.in_valid = 1'b0;
        tick;
        chk("A.we_off", 32'(bus.imem_we), 0);
        chk("A.done", 32'(bus.done), 1);
        chk("A.busy_off", 32'(bus.busy), 0);
        chk("A.nwr", 32'(wq_a.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk("A.qa", wq_a[i], 32'(i));
            chk("A.qd", wq_d[i], wa[i]);
        end

        // Restart from DONE; stalled beats; start ignored in LOAD
        bus.start  = 1'b1;
        bus.length = 11'd3;
        tick;
        bus.start = 1'b0;
        wq_a.delete();
        wq_d.delete();
        chk("B.crst", 32'(bus.core_rst_n), 0);
        chk("B.done", 32'(bus.done), 0);
        chk("B.busy", 32'(bus.busy), 1);
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = WW'(32'h100 + c);
            bus.start    = (c == 1);
            bus.length   = (c == 1) ? 11'd0 : 11'd3;
            tick;
            chk("B.we", 32'(bus.imem_we), 32'(c % 2 == 0));
            if (c % 2 == 0)
                chk("B.addr", 32'(bus.imem_addr), 32'(c / 2));
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("B.done2", 32'(bus.done), 1);
        tick;
        chk("B.nwr", 32'(wq_a.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("B.qa", wq_a[i], 32'(i));
            chk("B.qd", wq_d[i], 32'h100 + 32'(2 * i));
        end

        // Oversize length, then zero length
        wq_a.delete();
        bus.start  = 1'b1;
        bus.length = 11'd1025;
        tick;
        chk("C.err", 32'(bus.err), 1);
        chk("C.crst", 32'(bus.core_rst_n), 0);
        chk("C.done", 32'(bus.done), 0);
        chk("C.busy", 32'(bus.busy), 0);
        chk("C.rdy", 32'(bus.in_ready), 0);
        bus.length = 11'd0;
        tick;
        bus.start = 1'b0;
        chk("C.done0", 32'(bus.done), 1);
        chk("C.err0", 32'(bus.err), 0);
        chk("C.crst0", 32'(bus.core_rst_n), 1);
        chk("C.we0", 32'(bus.imem_we), 0);
        tick;
        chk("C.nwr", 32'(wq_a.size()), 0);

        // Full-depth length is legal
        bus.start  = 1'b1;
        bus.length = 11'd1024;
        tick;
        bus.start = 1'b0;
        chk("D.busy", 32'(bus.busy), 1);
        chk("D.err", 32'(bus.err), 0);
        chk("D.rdy", 32'(bus.in_ready), 1);

        // Reset after two beats
        bus.in_valid = 1'b1;
        bus.in_data  = 19'h2AAAA;
        tick;
        bus.in_data = 19'h15555;
        tick;
        chk("D.we", 32'(bus.imem_we), 1);
        chk("D.addr", 32'(bus.imem_addr), 1);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_rst("D.async");
        #1 rst = 1'b0;
        tick;
        chk("D.crst", 32'(bus.core_rst_n), 0);
        wq_a.delete();
        wq_d.delete();
        bus.start  = 1'b1;
        bus.length = 11'd1;
        tick;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 19'h3C3C3;
        tick;
        bus.in_valid = 1'b0;
        chk("E.we", 32'(bus.imem_we), 1);
        chk("E.addr", 32'(bus.imem_addr), 0);
        chk("E.wd", 32'(bus.imem_wd), 32'h3C3C3);
        chk("E.done", 32'(bus.done), 1);
        chk("E.crst", 32'(bus.core_rst_n), 1);
        tick;
        chk("E.we_off", 32'(bus.imem_we), 0);
        chk("E.nwr", 32'(wq_a.size()), 1);
`else
        // Two words summing to 0 mod 2^19, good checksum
        bus.start  = 1'b1;
        bus.length = 11'd2;
        tick;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 19'h40000;
        tick;
        tick;
        chk("K.rdy", 32'(bus.in_ready), 1);
        chk("K.we", 32'(bus.imem_we), 1);
        chk("K.addr", 32'(bus.imem_addr), 1);
        chk("K.crst", 32'(bus.core_rst_n), 0);
        chk("K.done", 32'(bus.done), 0);
        bus.in_data = 19'h00000;
        tick;
        bus.in_valid = 1'b0;
        chk("K.done2", 32'(bus.done), 1);
        chk("K.err", 32'(bus.err), 0);
        chk("K.we2", 32'(bus.imem_we), 0);

        // Same words, wrong checksum
        bus.start = 1'b1;
        tick;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 19'h40000;
        tick;
        tick;
        bus.in_data = 19'h00001;
        tick;
        bus.in_valid = 1'b0;
        chk("L.err", 32'(bus.err), 1);
        chk("L.done", 32'(bus.done), 0);
        chk("L.crst", 32'(bus.core_rst_n), 0);
        chk("L.we", 32'(bus.imem_we), 0);

        // Zero length goes straight to the checksum beat
        bus.start  = 1'b1;
        bus.length = 11'd0;
        tick;
        bus.start = 1'b0;
        chk("M.rdy", 32'(bus.in_ready), 1);
        chk("M.busy", 32'(bus.busy), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 19'h00000;
        tick;
        bus.in_valid = 1'b0;
        chk("M.done", 32'(bus.done), 1);
        chk("M.we", 32'(bus.imem_we), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
